// File: rtl/rx_frame_ctrl_if.sv
// Signal bundle between the receive pipeline, rx_frame_ctrl and its consumer.
// The slave modport is the controller side; master is the surrounding environment.
interface rx_frame_ctrl_if;
    logic        crsdv;
    logic        fw_axiiv;
    logic        agg_axiiv;
    logic [31:0] agg_axiid;
    logic        ck_done;
    logic        ck_kill;
    logic        axiov;
    logic [31:0] axiod;
    logic        axiir;
    logic [15:0] good_cnt;
    logic [15:0] bad_cnt;
    logic [15:0] filt_cnt;
    logic [15:0] ovf_cnt;
    logic        busy;

    modport master (
        output crsdv, fw_axiiv, agg_axiiv, agg_axiid, ck_done, ck_kill, axiir,
        input  axiov, axiod, good_cnt, bad_cnt, filt_cnt, ovf_cnt, busy
    );

    modport slave (
        input  crsdv, fw_axiiv, agg_axiiv, agg_axiid, ck_done, ck_kill, axiir,
        output axiov, axiod, good_cnt, bad_cnt, filt_cnt, ovf_cnt, busy
    );
endinterface

// File: rtl/rx_frame_ctrl.sv
// Per-frame receive sequencer: collects firewall/checksum/aggregate verdicts, commits
// accepted payload words to a small FIFO, keeps saturating stats and enforces the IFG.
module rx_frame_ctrl #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned CK_TIMEOUT = 64,
    parameter int unsigned IFG_CYCLES = 48
) (
    input  logic            clk,
    input  logic            rstn,
    rx_frame_ctrl_if.slave  bus
);

    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW = PtrW + 1;
    localparam int unsigned TmrW = $clog2(CK_TIMEOUT + 1);
    localparam int unsigned GapW = $clog2(IFG_CYCLES + 1);

    typedef enum logic [1:0] {StIdle, StRecv, StCheck, StIfg} state_e;

    state_e            state_q, state_d;
    logic              fw_hit_q, fw_hit_d;
    logic              word_v_q, word_v_d;
    logic              ck_ok_q, ck_ok_d;
    logic              ck_bad_q, ck_bad_d;
    logic [31:0]       hold_q, hold_d;
    logic [TmrW-1:0]   timer_q, timer_d;
    logic [GapW-1:0]   gap_q, gap_d;
    logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]   count_q;
    logic [15:0]       good_q, bad_q, filt_q, ovf_q;
    logic [31:0]       mem_q [FIFO_DEPTH];

    logic push, pop, full, head_v;
    logic inc_good, inc_bad, inc_filt, inc_ovf;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    assign head_v = (count_q != '0);
    assign full   = (count_q == CntW'(FIFO_DEPTH));
    assign pop    = head_v && bus.axiir;

    always_comb begin
        state_d  = state_q;
        fw_hit_d = fw_hit_q;
        word_v_d = word_v_q;
        ck_ok_d  = ck_ok_q;
        ck_bad_d = ck_bad_q;
        hold_d   = hold_q;
        timer_d  = timer_q;
        gap_d    = gap_q;
        push     = 1'b0;
        inc_good = 1'b0;
        inc_bad  = 1'b0;
        inc_filt = 1'b0;
        inc_ovf  = 1'b0;

        case (state_q)
            StIdle: begin
                fw_hit_d = 1'b0;
                word_v_d = 1'b0;
                ck_ok_d  = 1'b0;
                ck_bad_d = 1'b0;
                timer_d  = '0;
                gap_d    = '0;
                if (bus.crsdv) state_d = StRecv;
            end
            StRecv, StCheck: begin
                if (bus.agg_axiiv) begin
                    hold_d   = bus.agg_axiid;
                    word_v_d = 1'b1;
                end
                if (bus.fw_axiiv) fw_hit_d = 1'b1;
                if (bus.ck_done)  ck_ok_d  = 1'b1;
                if (bus.ck_kill)  ck_bad_d = 1'b1;

                if (state_q == StRecv) begin
                    if (!bus.crsdv) begin
                        state_d = StCheck;
                        timer_d = '0;
                    end
                end else if (ck_ok_d || ck_bad_d) begin
                    // Decision uses flags merged with this cycle's inputs; kill wins over done.
                    state_d = StIfg;
                    gap_d   = '0;
                    if (ck_bad_d)                    inc_bad  = 1'b1;
                    else if (!fw_hit_d || !word_v_d) inc_filt = 1'b1;
                    else if (full)                   inc_ovf  = 1'b1;
                    else begin
                        push     = 1'b1;
                        inc_good = 1'b1;
                    end
                end else if (timer_q == TmrW'(CK_TIMEOUT - 1)) begin
                    state_d = StIfg;
                    gap_d   = '0;
                    inc_bad = 1'b1;
                end else begin
                    timer_d = timer_q + TmrW'(1);
                end
            end
            StIfg: begin
                if (bus.crsdv) begin
                    gap_d = '0;
                end else if (gap_q == GapW'(IFG_CYCLES - 1)) begin
                    state_d = StIdle;
                end else begin
                    gap_d = gap_q + GapW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q  <= StIdle;
            fw_hit_q <= 1'b0;
            word_v_q <= 1'b0;
            ck_ok_q  <= 1'b0;
            ck_bad_q <= 1'b0;
            hold_q   <= '0;
            timer_q  <= '0;
            gap_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            good_q   <= '0;
            bad_q    <= '0;
            filt_q   <= '0;
            ovf_q    <= '0;
        end else begin
            state_q  <= state_d;
            fw_hit_q <= fw_hit_d;
            word_v_q <= word_v_d;
            ck_ok_q  <= ck_ok_d;
            ck_bad_q <= ck_bad_d;
            hold_q   <= hold_d;
            timer_q  <= timer_d;
            gap_q    <= gap_d;
            if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + CntW'(1);
                2'b01:   count_q <= count_q - CntW'(1);
                default: count_q <= count_q;
            endcase
            if (inc_good) good_q <= sat_inc(good_q);
            if (inc_bad)  bad_q  <= sat_inc(bad_q);
            if (inc_filt) filt_q <= sat_inc(filt_q);
            if (inc_ovf)  ovf_q  <= sat_inc(ovf_q);
        end
    end

    // Storage needs no reset: only entries below count_q are ever observed.
    always_ff @(posedge clk) begin
        if (rstn && push) mem_q[wr_ptr_q] <= hold_d;
    end

    assign bus.axiov    = head_v;
    assign bus.axiod    = head_v ? mem_q[rd_ptr_q] : 32'h0;
    assign bus.good_cnt = good_q;
    assign bus.bad_cnt  = bad_q;
    assign bus.filt_cnt = filt_q;
    assign bus.ovf_cnt  = ovf_q;
    assign bus.busy     = (state_q != StIdle);

endmodule

// File: doc/rx_frame_ctrl.md
# rx_frame_ctrl

Per-frame sequencer for the Ethernet receive path. It sits after the `rether` → `bitorder` → `firewall` / `cksum` → `aggregate` chain, in the `eth_refclk` domain.

- It tracks frame boundaries from the pipelined carrier-sense signal and collects the firewall, checksum and aggregate verdicts.
- It commits the frame's 32-bit payload word to a small output FIFO only when the frame is address-accepted and checksum-clean.
- It keeps saturating statistics counters and enforces an inter-frame gap before re-arming.

## Interface

Parameters:
- `FIFO_DEPTH`, default 4: output FIFO entries; must be a power of 2, ≥2.
- `CK_TIMEOUT`, default 64: max cycles spent in CHECK waiting for a checksum verdict.
- `IFG_CYCLES`, default 48: consecutive `crsdv`-low cycles required before re-arm (96 bit times at 2 bits/cycle).

Ports:
- `clk`, in, 1: `eth_refclk`, 50 MHz. Single clock.
- `rstn`, in, 1: synchronous, active-low reset.
- `crsdv`, in, 1: registered RMII carrier-sense/data-valid.
- `fw_axiiv`, in, 1: firewall output valid. Any pulse marks the frame as address-accepted.
- `agg_axiiv`, in, 1: aggregate word valid.
- `agg_axiid`, in, 32: aggregate word.
- `ck_done`, in, 1: checksum complete, 1-cycle pulse.
- `ck_kill`, in, 1: checksum failed, 1-cycle pulse.
- `axiov`, out, 1: FIFO head valid.
- `axiod`, out, 32: FIFO head data.
- `axiir`, in, 1: consumer ready. Pop occurs when `axiov && axiir`.
- `good_cnt`, out, 16: frames committed.
- `bad_cnt`, out, 16: checksum kills plus timeouts.
- `filt_cnt`, out, 16: frames rejected by firewall or carrying no data word.
- `ovf_cnt`, out, 16: good frames dropped because the FIFO was full.
- `busy`, out, 1: high when state ≠ IDLE.

## Operation

States and transitions:
- **IDLE:** on `crsdv`=1 → RECV. Clear flags `fw_hit`, `word_v`, `ck_ok`, `ck_bad`.
- **RECV:**
  - `agg_axiiv` loads `agg_axiid` into the hold register and sets `word_v`. If several words arrive, the last one wins.
  - `fw_axiiv` sets `fw_hit`.
  - `ck_done` sets `ck_ok`; `ck_kill` sets `ck_bad`.
  - On `crsdv`=0 → CHECK and clear the timeout timer.
- **CHECK:** keeps latching the same inputs as RECV. A verdict is available when `ck_ok`, `ck_bad`, `ck_done` or `ck_kill` is set (flag or same-cycle input). With a verdict available, resolve in this priority order, update exactly one counter, then → IFG:
  1. `ck_bad`/`ck_kill` → `bad_cnt`++. Kill wins over done.
  2. `!fw_hit` or `!word_v` → `filt_cnt`++.
  3. FIFO full → `ovf_cnt`++.
  4. Otherwise push the hold word and `good_cnt`++.
- **CHECK timeout:** with no verdict, the timer increments each cycle. At timer = `CK_TIMEOUT`-1: `bad_cnt`++ and → IFG.
- **IFG:** gap counter increments while `crsdv`=0 and resets to 0 whenever `crsdv`=1. When the counter reaches `IFG_CYCLES`-1 with `crsdv`=0 → IDLE. A frame starting inside the gap is ignored entirely; no counter changes.

Counters and FIFO rules:
- All counters saturate at 0xFFFF.
- "Full" means occupancy = `FIFO_DEPTH` at the decision edge. A same-cycle pop does not free space for the push, so the frame is counted in `ovf_cnt`.
- Simultaneous push and pop when not full: both take effect and occupancy is unchanged.
- Pointers are log2(`FIFO_DEPTH`) bits and wrap naturally. The occupancy register is one bit wider.
- `ck_done`/`ck_kill` pulses seen in IDLE or IFG are discarded.

## Timing

- **Reset:** while `rstn`=0 at an edge, the next state is:
  - state IDLE, FIFO empty, all flags and timers 0;
  - `axiov`=0, `axiod`=0, all counters 0, `busy`=0.
- **Reset mid-frame:** the frame is discarded and no counter changes.
- **IDLE → RECV:** `busy`=1 the cycle after the first `crsdv`=1 sample.
- **Commit latency:** if `ck_done` arrives in the first CHECK cycle, the push and the counter update land on that edge, and `axiov`=1 with the word on `axiod` in the next cycle. Minimum latency from `crsdv` falling to `axiov` is 2 cycles.
- **Output registers:** `axiod` is a registered FIFO-head read and is stable while `axiov && !axiir`. After a pop, the next entry (if any) appears the following cycle.
- **Timeout:** a frame with no verdict leaves CHECK exactly `CK_TIMEOUT` cycles after entering it.
- **Minimum frame-to-frame spacing:** `IFG_CYCLES` low cycles after the decision edge.

## Test plan

- **Clean frame:** `crsdv` high 100 cycles; `fw_axiiv` pulse at cycle 20; `agg_axiid`=0xDEADBEEF at cycle 60; `ck_done` 1 cycle after `crsdv` falls → `axiov`=1, `axiod`=0xDEADBEEF, `good_cnt`=1, other counters 0.
- **Kill precedence:** as above but `ck_done` and `ck_kill` in the same cycle → no push, `bad_cnt`=1.
- **Filter/no data:**
  - frame with no `fw_axiiv` → `filt_cnt`=1;
  - frame with `fw_axiiv` but no `agg_axiiv` → `filt_cnt`=2;
  - FIFO stays empty throughout.
- **Overflow:** `axiir`=0, 5 clean frames with words 1..5 (`FIFO_DEPTH`=4) → `good_cnt`=4, `ovf_cnt`=1. Raising `axiir` then pops 1,2,3,4 in order, after which `axiov`=0.
- **Timeout and IFG:**
  - frame with no checksum pulse → `bad_cnt` increments exactly 64 cycles after entering CHECK;
  - a second frame starting 10 cycles into IFG is ignored, with counters unchanged.
- **Reset mid-RECV:** `rstn` low 1 cycle at cycle 50 of a frame → state IDLE, counters 0, `axiov`=0. The subsequent clean frame commits normally.
